vaccine_hit_tracker: RTL and testbench
======================================

Name: vaccine_hit_tracker

Overview:
- Downstream consumer of the collision controller's per-frame hit pulse and clamp index.
- Tracks which of the vaccine objects are still on screen and drives their per-object enables to the vaccine drawers.
- Keeps a 2-digit BCD score and runs a small round FSM: idle, play, cleared, respawn.

Parameters:
- NUM_VACCINES, 10, number of vaccine objects; legal range 1..15.
- RESPAWN_FRAMES, 90, number of startOfFrame pulses counted in CLEARED before all vaccines are restored.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- startOfFrame  in  1  one-cycle pulse at each frame start
- startGame  in  1  one-cycle pulse that starts or restarts a round
- hitPulse  in  1  single hit pulse from the collision controller; at most one per frame upstream
- hitIndex  in  4  index of the collided vaccine, 0..NUM_VACCINES-1; 15 = none/error
- vaccineEnable  out  NUM_VACCINES  bit i high = vaccine i drawn and collidable
- scoreOnes  out  4  BCD ones digit
- scoreTens  out  4  BCD tens digit
- levelDone  out  1  one-cycle pulse when the last vaccine is collected
- roundState  out  2  IDLE=0, PLAY=1, CLEARED=2

Behaviour:
- Interface: reset resetN, asynchronous, active-low; clock clk. All state is in registers updated on posedge clk.
- Reset values:
  - vaccineEnable = all ones
  - scoreOnes = 0, scoreTens = 0
  - levelDone = 0
  - roundState = IDLE
  - frame counter = 0
  - frameHitTaken flag = 0
- IDLE:
  - hitPulse ignored.
  - startGame -> PLAY, vaccineEnable = all ones, score = 00, flag cleared.
- PLAY, hit acceptance: a hit is accepted when all of the following hold:
  - hitPulse = 1
  - hitIndex < NUM_VACCINES
  - vaccineEnable[hitIndex] = 1
  - frameHitTaken = 0, or startOfFrame = 1 in the same cycle
- PLAY, effect of an accepted hit, visible the next cycle (1-cycle latency):
  - vaccineEnable[hitIndex] cleared.
  - Score += 1 in BCD: ones 9 -> 0 with tens +1.
  - Score saturates at 99; the enable bit is still cleared.
  - frameHitTaken set.
- PLAY, rejected hits: index 15, index >= NUM_VACCINES, already-disabled vaccine, or second hit in the same frame. These are ignored, with no state change.
- frameHitTaken: cleared by startOfFrame. If startOfFrame and an accepted hit coincide, the hit is counted and the flag ends set; it belongs to the new frame.
- Last vaccine: if an accepted hit clears the last set bit, then next cycle:
  - roundState = CLEARED
  - levelDone = 1 for exactly one cycle
  - frame counter = 0
- CLEARED:
  - hitPulse ignored.
  - Each startOfFrame increments the counter.
  - When the counter reaches RESPAWN_FRAMES - 1 and startOfFrame occurs: vaccineEnable = all ones, roundState = PLAY, counter = 0. Score is retained.
- startGame in PLAY or CLEARED: restart to PLAY with full mask, score 00, counter 0, flag 0. This has priority over a simultaneous hit or respawn.
- Frame counter width: ceil(log2(RESPAWN_FRAMES + 1)) bits; no wrap while in CLEARED.
- Reset asserted mid-round: all registers return to reset values immediately (asynchronous).
- Outputs are registered and glitch-free; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then startGame -> roundState = 1, vaccineEnable = 10'h3FF, score 00. A hitPulse with hitIndex = 3 beforehand (in IDLE) leaves the mask at 3FF.
- PLAY, hitPulse with hitIndex = 4 -> next cycle bit 4 cleared, score 01. A second hitPulse with index 6 in the same frame -> ignored. After startOfFrame, index 6 -> bit 6 cleared, score 02.
- hitIndex = 15, hitIndex = 12, and repeated index 4 each -> no change to mask or score.
- startOfFrame and hitPulse with index 0 in the same cycle, flag previously set -> hit accepted. A further hit in that frame -> rejected.
- Collect all 10 (one per frame) -> levelDone high exactly one cycle, roundState = 2, score 10. After 90 startOfFrame pulses -> mask 3FF, roundState = 1, score still 10.
- Score preloaded to 99 via repeated rounds, then another hit -> score stays 99 and the bit clears. startGame mid-CLEARED -> PLAY, score 00. resetN low mid-PLAY -> all outputs at reset values.

Source files
------------

// File: rtl/vaccine_hit_tracker_if.sv
// Bundle between the frame/collision logic and the vaccine hit tracker:
// frame and hit strobes in, per-vaccine enables, score and round status out.
interface vaccine_hit_tracker_if #(
    parameter int NUM_VACCINES = 10
);
    logic                    startOfFrame;
    logic                    startGame;
    logic                    hitPulse;
    logic [3:0]              hitIndex;
    logic [NUM_VACCINES-1:0] vaccineEnable;
    logic [3:0]              scoreOnes;
    logic [3:0]              scoreTens;
    logic                    levelDone;
    logic [1:0]              roundState;

    modport master (
        output startOfFrame, startGame, hitPulse, hitIndex,
        input  vaccineEnable, scoreOnes, scoreTens, levelDone, roundState
    );

    modport slave (
        input  startOfFrame, startGame, hitPulse, hitIndex,
        output vaccineEnable, scoreOnes, scoreTens, levelDone, roundState
    );
endinterface

// File: rtl/vaccine_hit_tracker.sv
// Tracks which vaccines remain on screen, keeps a saturating 2-digit BCD score
// and sequences rounds (idle, play, cleared, respawn after a frame delay).
module vaccine_hit_tracker #(
    parameter int NUM_VACCINES   = 10,
    parameter int RESPAWN_FRAMES = 90
) (
    input  logic                    clk,
    input  logic                    resetN,
    vaccine_hit_tracker_if.slave    bus
);
    localparam int                      CNT_W    = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [4:0]              NUM_V5   = 5'(NUM_VACCINES);
    localparam logic [NUM_VACCINES-1:0] ALL_ON   = {NUM_VACCINES{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        CLEARED = 2'd2
    } state_t;

    // Saturating BCD increment of {tens, ones}; 99 stays 99.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if (tens == 4'd9 && ones == 4'd9) begin
            res = {tens, ones};
        end else if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    state_t                  state_r, state_s;
    logic [NUM_VACCINES-1:0] mask_r, mask_s, mask_hit_s;
    logic [3:0]              ones_r, ones_s, tens_r, tens_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    flag_r, flag_s;
    logic                    done_r, done_s;
    logic [15:0]             mask_ext_s, cleared_ext_s;
    logic [7:0]              score_inc_s;
    logic                    hit_ok_s;

    // Hit qualification; the mask is widened so any 4-bit index is a legal select.
    always_comb begin
        mask_ext_s    = 16'(mask_r);
        cleared_ext_s = mask_ext_s & ~(16'd1 << bus.hitIndex);
        mask_hit_s    = cleared_ext_s[NUM_VACCINES-1:0];
        score_inc_s   = bcd_inc(tens_r, ones_r);
        hit_ok_s      = bus.hitPulse && ({1'b0, bus.hitIndex} < NUM_V5) &&
                        mask_ext_s[bus.hitIndex] && (!flag_r || bus.startOfFrame);
    end

    // Round FSM next-state and datapath updates; startGame outranks hits and respawn.
    always_comb begin
        state_s = state_r;
        mask_s  = mask_r;
        ones_s  = ones_r;
        tens_s  = tens_r;
        cnt_s   = cnt_r;
        flag_s  = bus.startOfFrame ? 1'b0 : flag_r;
        done_s  = 1'b0;
        if (bus.startGame) begin
            state_s = PLAY;
            mask_s  = ALL_ON;
            ones_s  = 4'd0;
            tens_s  = 4'd0;
            cnt_s   = '0;
            flag_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                PLAY: begin
                    if (hit_ok_s) begin
                        mask_s = mask_hit_s;
                        tens_s = score_inc_s[7:4];
                        ones_s = score_inc_s[3:0];
                        flag_s = 1'b1;
                        if (mask_hit_s == '0) begin
                            state_s = CLEARED;
                            done_s  = 1'b1;
                            cnt_s   = '0;
                        end else begin
                            state_s = PLAY;
                        end
                    end else begin
                        state_s = PLAY;
                    end
                end
                CLEARED: begin
                    if (bus.startOfFrame) begin
                        if (cnt_r == CNT_LAST) begin
                            state_s = PLAY;
                            mask_s  = ALL_ON;
                            cnt_s   = '0;
                        end else begin
                            cnt_s   = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= IDLE;
            mask_r  <= ALL_ON;
            ones_r  <= 4'd0;
            tens_r  <= 4'd0;
            cnt_r   <= '0;
            flag_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            mask_r  <= mask_s;
            ones_r  <= ones_s;
            tens_r  <= tens_s;
            cnt_r   <= cnt_s;
            flag_r  <= flag_s;
            done_r  <= done_s;
        end
    end

    assign bus.vaccineEnable = mask_r;
    assign bus.scoreOnes     = ones_r;
    assign bus.scoreTens     = tens_r;
    assign bus.levelDone     = done_r;
    assign bus.roundState    = state_r;
endmodule

// File: tb/tb_vaccine_hit_tracker.sv
// Self-checking bench for vaccine_hit_tracker: directed scenarios plus random
// stimulus against an integer-score / per-vaccine-flag reference model.
module tb_vaccine_hit_tracker;
    localparam int NV = 10;
    localparam int RF = 90;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    vaccine_hit_tracker_if #(.NUM_VACCINES(NV)) bus ();

    vaccine_hit_tracker #(.NUM_VACCINES(NV), .RESPAWN_FRAMES(RF)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: round 0/1/2, per-vaccine presence, integer score.
    int m_state;
    bit m_en[NV];
    int m_score;
    int m_cnt;
    bit m_flag;
    bit m_done;

    function automatic void model_reset();
        m_state = 0;
        foreach (m_en[i]) m_en[i] = 1'b1;
        m_score = 0;
        m_cnt   = 0;
        m_flag  = 1'b0;
        m_done  = 1'b0;
    endfunction

    function automatic void model_step(bit sof, bit sg, bit hp, int idx);
        bit accept;
        int left;
        m_done = 1'b0;
        if (sg) begin
            m_state = 1;
            foreach (m_en[i]) m_en[i] = 1'b1;
            m_score = 0;
            m_cnt   = 0;
            m_flag  = 1'b0;
            return;
        end
        if (sof) m_flag = 1'b0;
        if (m_state == 1) begin
            accept = hp && (idx < NV) && m_en[idx] && (!m_flag || sof);
            if (accept) begin
                m_en[idx] = 1'b0;
                if (m_score < 99) m_score++;
                m_flag = 1'b1;
                left = 0;
                foreach (m_en[i]) left += int'(m_en[i]);
                if (left == 0) begin
                    m_state = 2;
                    m_done  = 1'b1;
                    m_cnt   = 0;
                end
            end
        end else if (m_state == 2 && sof) begin
            if (m_cnt == RF - 1) begin
                foreach (m_en[i]) m_en[i] = 1'b1;
                m_state = 1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
    endfunction

    function automatic logic [20:0] exp_vec();
        logic [NV-1:0] mask;
        foreach (m_en[i]) mask[i] = m_en[i];
        return {mask, 4'(m_score / 10), 4'(m_score % 10), m_done, 2'(m_state)};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.vaccineEnable, bus.scoreTens, bus.scoreOnes, bus.levelDone, bus.roundState};
    endfunction

    task automatic drive(input bit sof, input bit sg, input bit hp, input int idx);
        bus.startOfFrame = sof;
        bus.startGame    = sg;
        bus.hitPulse     = hp;
        bus.hitIndex     = 4'(idx);
        model_step(sof, sg, hp, idx);
        @(posedge clk);
        #1;
        bus.startOfFrame = 1'b0;
        bus.startGame    = 1'b0;
        bus.hitPulse     = 1'b0;
        bus.hitIndex     = 4'd0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== {10'h3FF, 4'd0, 4'd0, 1'b0, 2'd0} || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset: got %h expected %h", dut_vec(), exp_vec());
        end
        @(negedge clk) resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_start();
        drive(1'b0, 1'b0, 1'b1, 3);
        checks++;
        if (bus.vaccineEnable !== 10'h3FF || bus.roundState !== 2'd0) begin
            failures++;
            $display("FAIL idle_hit: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (dut_vec() !== {10'h3FF, 4'd0, 4'd0, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL start: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_hits();
        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1, 4);
        checks++;
        if (bus.vaccineEnable !== 10'h3EF || {bus.scoreTens, bus.scoreOnes} !== 8'h01) begin
            failures++;
            $display("FAIL hit4: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1'b0, 1'b0, 1'b1, 6);
        checks++;
        if (bus.vaccineEnable !== 10'h3EF || {bus.scoreTens, bus.scoreOnes} !== 8'h01) begin
            failures++;
            $display("FAIL second_in_frame: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1, 6);
        checks++;
        if (bus.vaccineEnable !== 10'h3AF || {bus.scoreTens, bus.scoreOnes} !== 8'h02) begin
            failures++;
            $display("FAIL hit6: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_rejects();
        int idx_list[3] = '{15, 12, 4};
        drive(1'b1, 1'b0, 1'b0, 0);
        foreach (idx_list[k]) begin
            drive(1'b0, 1'b0, 1'b1, idx_list[k]);
            checks++;
            if (bus.vaccineEnable !== 10'h3AF || {bus.scoreTens, bus.scoreOnes} !== 8'h02) begin
                failures++;
                $display("FAIL reject_%0d: got %h expected %h", idx_list[k], dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_sof_coincide();
        drive(1'b0, 1'b0, 1'b1, 7);
        drive(1'b1, 1'b0, 1'b1, 0);
        checks++;
        if (bus.vaccineEnable !== 10'h32E || {bus.scoreTens, bus.scoreOnes} !== 8'h04) begin
            failures++;
            $display("FAIL sof_and_hit: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1'b0, 1'b0, 1'b1, 1);
        checks++;
        if (bus.vaccineEnable !== 10'h32E || {bus.scoreTens, bus.scoreOnes} !== 8'h04) begin
            failures++;
            $display("FAIL after_sof_hit: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_clear_respawn();
        drive(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < NV; i++) drive(1'b1, 1'b0, 1'b1, i);
        checks++;
        if (dut_vec() !== {10'h000, 4'd1, 4'd0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL level_done: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (bus.levelDone !== 1'b0 || bus.roundState !== 2'd2) begin
            failures++;
            $display("FAIL done_one_cycle: got %h expected %h", dut_vec(), exp_vec());
        end
        for (int k = 0; k < RF - 1; k++) drive(1'b1, 1'b0, 1'b1, 0);
        checks++;
        if (bus.roundState !== 2'd2 || bus.vaccineEnable !== 10'h000) begin
            failures++;
            $display("FAIL before_respawn: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (dut_vec() !== {10'h3FF, 4'd1, 4'd0, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL respawn: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_saturate();
        int perm[NV];
        int j, t;
        drive(1'b0, 1'b1, 1'b0, 0);
        for (int r = 0; r < 9; r++) begin
            foreach (perm[i]) perm[i] = i;
            for (int i = NV - 1; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            foreach (perm[i]) drive(1'b1, 1'b0, 1'b1, perm[i]);
            for (int k = 0; k < RF; k++) drive(1'b1, 1'b0, 1'b0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL round_%0d: got %h expected %h", r, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b1, i);
        checks++;
        if (dut_vec() !== {10'h200, 4'd9, 4'd9, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL score_99: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1'b1, 1'b0, 1'b1, 9);
        checks++;
        if (dut_vec() !== {10'h000, 4'd9, 4'd9, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL saturate: got %h expected %h", dut_vec(), exp_vec());
        end
        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (dut_vec() !== {10'h3FF, 4'd0, 4'd0, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL restart_cleared: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b1, 5);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== {10'h3FF, 4'd0, 4'd0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_mid: got %h expected %h", dut_vec(), exp_vec());
        end
        @(negedge clk) resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit sof, sg, hp;
        int idx;
        drive(1'b0, 1'b1, 1'b0, 0);
        for (int n = 0; n < 4000; n++) begin
            sof = ($urandom_range(3, 0) == 0);
            sg  = ($urandom_range(399, 0) == 0);
            hp  = $urandom_range(1, 0) == 1;
            idx = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0))
                                              : int'($urandom_range(NV - 1, 0));
            drive(sof, sg, hp, idx);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d: got %h expected %h", n, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.startGame    = 1'b0;
        bus.hitPulse     = 1'b0;
        bus.hitIndex     = 4'd0;
        model_reset();
        test_reset();
        test_start();
        test_hits();
        test_rejects();
        test_sof_coincide();
        test_clear_respawn();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
